// File: rtl/mxint_pkg.sv
// mxint_pkg: shared MXINT number-format helpers. The exponential unit, this
// sum stage and the reciprocal stage all derive their fixed-point layout here.
package mxint_pkg;

    // Exponent bias; the aligned shift is exp + bias, which spans 0 .. 2*bias-1.
    function automatic int unsigned mx_bias(input int unsigned exp_w);
        return 32'd1 << (exp_w - 32'd1);
    endfunction

    // Width of one mantissa after alignment to the common grid.
    function automatic int unsigned mx_aligned_width(input int unsigned man_w,
                                                     input int unsigned exp_w);
        return man_w + 32'd2 * mx_bias(exp_w) - 32'd1;
    endfunction

    // Width of the sum of n aligned elements.
    function automatic int unsigned mx_tree_width(input int unsigned man_w,
                                                  input int unsigned exp_w,
                                                  input int unsigned n);
        return mx_aligned_width(man_w, exp_w) + $clog2(n);
    endfunction

    // Width of a full row sum (n = elements per block * blocks per row).
    function automatic int unsigned mx_full_width(input int unsigned man_w,
                                                  input int unsigned exp_w,
                                                  input int unsigned n);
        return mx_aligned_width(man_w, exp_w) + $clog2(n);
    endfunction

    // Fraction bits of the aligned grid: mantissa fraction plus the bias.
    function automatic int unsigned mx_frac_bits(input int unsigned man_w,
                                                 input int unsigned exp_w);
        return man_w - 32'd2 + mx_bias(exp_w);
    endfunction

    localparam int unsigned MX_DEFAULT_FRAC_BITS = mx_frac_bits(10, 4);

endpackage

// File: rtl/mxint_align_tree.sv
// mxint_align_tree: aligns each (mantissa, exponent) pair of a block onto the
// common fixed-point grid and sums the block. Purely combinational.
module mxint_align_tree import mxint_pkg::*; #(
    parameter int unsigned MAN_W = 10,
    parameter int unsigned EXP_W = 4,
    parameter int unsigned N     = 16
) (
    input  logic [MAN_W*N-1:0]                       man_i,
    input  logic [EXP_W*N-1:0]                       exp_i,
    output logic [mx_tree_width(MAN_W, EXP_W, N)-1:0] sum_o
);

    localparam int unsigned AW = mx_aligned_width(MAN_W, EXP_W);
    localparam int unsigned SW = mx_tree_width(MAN_W, EXP_W, N);

    logic [MAN_W-1:0] man;
    logic [EXP_W-1:0] shamt;
    logic [AW-1:0]    elem;

    // Shift each element by exp + bias and reduce; adding the bias to a
    // two's-complement exponent is the same as inverting its sign bit.
    always_comb begin
        sum_o = '0;
        man   = '0;
        shamt = '0;
        elem  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            man               = man_i[i*MAN_W +: MAN_W];
            shamt             = exp_i[i*EXP_W +: EXP_W];
            shamt[EXP_W-1]    = ~shamt[EXP_W-1];
            elem              = AW'(man) << shamt;
            sum_o             = sum_o + SW'(elem);
        end
    end

endmodule

// File: rtl/mxint_exp_sum.sv
// mxint_exp_sum: softmax denominator. Aligns and sums each block of exp
// results (S1), accumulates BLOCK_COUNT blocks into a row sum and presents it
// on a valid/ready output register.
// Optional build macro MXINT_EXP_SUM_SAT_EN: saturate the output to all ones
// when the row sum exceeds DATA_OUT_WIDTH bits (default: wrap).
module mxint_exp_sum import mxint_pkg::*; #(
    parameter int unsigned DATA_IN_MAN_WIDTH = 10,
    parameter int unsigned DATA_IN_EXP_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE        = 16,
    parameter int unsigned BLOCK_COUNT       = 4,
    parameter int unsigned DATA_OUT_WIDTH    = 24
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [DATA_IN_MAN_WIDTH*BLOCK_SIZE-1:0]   mdata_in_0,
    input  logic [DATA_IN_EXP_WIDTH*BLOCK_SIZE-1:0]   edata_in_0,
    input  logic                                      data_in_0_valid,
    output logic                                      data_in_0_ready,
    output logic [DATA_OUT_WIDTH-1:0]                 data_out_0,
    output logic                                      data_out_0_valid,
    input  logic                                      data_out_0_ready
);

    localparam int unsigned TW = mx_tree_width(DATA_IN_MAN_WIDTH, DATA_IN_EXP_WIDTH, BLOCK_SIZE);
    localparam int unsigned FW = mx_full_width(DATA_IN_MAN_WIDTH, DATA_IN_EXP_WIDTH,
                                               BLOCK_SIZE * BLOCK_COUNT);
    localparam int unsigned CW = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;

    logic [TW-1:0]             tree_sum;
    logic [TW-1:0]             s1_q, s1_d;
    logic                      s1_valid_q, s1_valid_d;
    logic [FW-1:0]             acc_q, acc_d, row_sum;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [DATA_OUT_WIDTH-1:0] out_q, out_d, out_cast;
    logic                      out_valid_q, out_valid_d;
    logic                      last_blk, out_free, s2_adv, in_fire;

    mxint_align_tree #(
        .MAN_W (DATA_IN_MAN_WIDTH),
        .EXP_W (DATA_IN_EXP_WIDTH),
        .N     (BLOCK_SIZE)
    ) u_tree (
        .man_i (mdata_in_0),
        .exp_i (edata_in_0),
        .sum_o (tree_sum)
    );

    // Handshake: stage 2 advances unless the last block of a row finds the
    // output register occupied and not being drained this cycle.
    always_comb begin
        last_blk        = (cnt_q == CW'(BLOCK_COUNT - 1));
        out_free        = !out_valid_q || data_out_0_ready;
        s2_adv          = s1_valid_q && (!last_blk || out_free);
        data_in_0_ready = !s1_valid_q || s2_adv;
        in_fire         = data_in_0_valid && data_in_0_ready;
        row_sum         = acc_q + FW'(s1_q);
    end

    // Narrow the full-width row sum to the output width.
    always_comb begin
        out_cast = DATA_OUT_WIDTH'(row_sum);
`ifdef MXINT_EXP_SUM_SAT_EN
        if ((row_sum >> DATA_OUT_WIDTH) != '0) out_cast = '1;
`endif
    end

    // Next state for S1, accumulator/counter and output register.
    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && data_out_0_ready) out_valid_d = 1'b0;
        if (s2_adv) begin
            s1_valid_d = 1'b0;
            if (last_blk) begin
                acc_d       = '0;
                cnt_d       = '0;
                out_d       = out_cast;
                out_valid_d = 1'b1;
            end else begin
                acc_d = row_sum;
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (in_fire) begin
            s1_d       = tree_sum;
            s1_valid_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out_0       = out_q;
    assign data_out_0_valid = out_valid_q;

endmodule
